// File: rtl/aes_host_if_if.sv
// Host-side bus bundle for aes_host_if: launch controls, bus-cycle qualifiers and data.
// master = host / testbench side, slave = aes_host_if.
interface aes_host_if_if #(
    parameter int BUS_W = 32
);
    logic             selCypher;
    logic             start;
    logic             RW;
    logic             adress;
    logic             initiate;
    logic [BUS_W-1:0] data_in;
    logic [BUS_W-1:0] data_out;
    logic             data_oe;

    modport master (
        output selCypher, start, RW, adress, initiate, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  selCypher, start, RW, adress, initiate, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/aes_host_if.sv
// Host-bus front end for an AES core: word-wise message/key assembly, start/done handshake,
// result read-back. Optional RUN watchdog enabled by defining AES_IF_TIMEOUT_EN.
module aes_host_if #(
    parameter int BUS_W       = 32,
    parameter int KEY_W       = 128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    aes_host_if_if.slave       bus,
    output logic [127:0]       core_msg,
    output logic [KEY_W-1:0]   core_key,
    output logic               core_mode,
    output logic               core_start,
    input  logic               core_done,
    input  logic [127:0]       core_result,
    output logic               busy,
    output logic               result_valid,
    output logic               err
);

    localparam int MW  = 128 / BUS_W;
    localparam int KW  = KEY_W / BUS_W;
    localparam int MPW = $clog2(MW);
    localparam int KPW = $clog2(KW);

    // Reject unsupported geometries at elaboration rather than building a broken datapath.
    if (BUS_W != 8 && BUS_W != 16 && BUS_W != 32 && BUS_W != 64) begin : g_bad_bus
        $error("aes_host_if: BUS_W must be 8, 16, 32 or 64");
    end
    if ((KEY_W != 128 && KEY_W != 192 && KEY_W != 256) || (KEY_W % BUS_W != 0)) begin : g_bad_key
        $error("aes_host_if: KEY_W must be 128/192/256 and a multiple of BUS_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_tmo
        $error("aes_host_if: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [BUS_W-1:0] msg_w [MW];
    logic [BUS_W-1:0] key_w [KW];
    logic [BUS_W-1:0] res_w [MW];
    logic [MPW-1:0]   msg_wp;
    logic [MPW-1:0]   rd_ptr;
    logic [KPW-1:0]   key_wp;
    logic             msg_full;
    logic             key_full;

`ifdef AES_IF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]    tmo_cnt;
`endif

    logic wr_cyc, rd_cyc, start_req, start_ok, start_bad;

    assign wr_cyc    = bus.initiate &  bus.RW;
    assign rd_cyc    = bus.initiate & ~bus.RW;
    // A start qualified by a bus cycle is not a launch request at all.
    assign start_req = bus.start & ~bus.initiate & (state != RUN);
    assign start_ok  = start_req &  (msg_full & key_full);
    assign start_bad = start_req & ~(msg_full & key_full);

    // Word 0 sits in the MSBs of every assembled vector.
    for (genvar i = 0; i < MW; i++) begin : g_msg
        assign core_msg[(MW-1-i)*BUS_W +: BUS_W] = msg_w[i];
    end
    for (genvar i = 0; i < KW; i++) begin : g_key
        assign core_key[(KW-1-i)*BUS_W +: BUS_W] = key_w[i];
    end

    always_comb begin
        bus.data_oe  = rd_cyc && (state == DONE);
        bus.data_out = '0;
        if (bus.data_oe) bus.data_out = res_w[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            msg_wp       <= '0;
            key_wp       <= '0;
            rd_ptr       <= '0;
            msg_full     <= 1'b0;
            key_full     <= 1'b0;
            core_mode    <= 1'b0;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            for (int i = 0; i < MW; i++) begin
                msg_w[i] <= '0;
                res_w[i] <= '0;
            end
            for (int i = 0; i < KW; i++) key_w[i] <= '0;
`ifdef AES_IF_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            core_start <= 1'b0;

            if (wr_cyc) begin
                if (state == RUN) begin
                    err <= 1'b1;
                end else if (bus.adress) begin
                    key_w[key_wp] <= bus.data_in;
                    if (key_wp == KPW'(KW-1)) begin
                        key_wp   <= '0;
                        key_full <= 1'b1;
                    end else begin
                        key_wp <= key_wp + 1'b1;
                    end
                end else begin
                    msg_w[msg_wp] <= bus.data_in;
                    if (msg_wp == MPW'(MW-1)) begin
                        msg_wp   <= '0;
                        msg_full <= 1'b1;
                    end else begin
                        msg_wp <= msg_wp + 1'b1;
                    end
                end
            end

            if (rd_cyc) begin
                if (state == DONE) rd_ptr <= (rd_ptr == MPW'(MW-1)) ? '0 : rd_ptr + 1'b1;
                else               err    <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        core_start   <= 1'b1;
                        core_mode    <= bus.selCypher;
                        msg_full     <= 1'b0;
                        rd_ptr       <= '0;
                        err          <= 1'b0;
`ifdef AES_IF_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end else if (start_bad) begin
                        err <= 1'b1;
                    end
                end
                RUN: begin
`ifdef AES_IF_TIMEOUT_EN
                    if (core_done) begin
                        for (int i = 0; i < MW; i++)
                            res_w[i] <= core_result[(MW-1-i)*BUS_W +: BUS_W];
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC-1)) begin
                        // Abandon the core; the previous result stays readable only via a new run.
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`else
                    if (core_done) begin
                        for (int i = 0; i < MW; i++)
                            res_w[i] <= core_result[(MW-1-i)*BUS_W +: BUS_W];
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_host_if.sv
// Bench for aes_host_if: directed table/sequences plus randomized traffic against a word-level model.
module tb_aes_host_if;
    localparam int BUS_W = 32;
    localparam int KEY_W = 128;
    localparam int MW    = 4;
    localparam int KW    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_host_if_if #(.BUS_W(BUS_W)) bus();

    logic [127:0]     core_msg;
    logic [KEY_W-1:0] core_key;
    logic             core_mode, core_start, core_done, busy, result_valid, err;
    logic [127:0]     core_result;

    aes_host_if #(.BUS_W(BUS_W), .KEY_W(KEY_W), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .core_msg(core_msg), .core_key(core_key), .core_mode(core_mode),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .busy(busy), .result_valid(result_valid), .err(err)
    );

    // Stub core: answers ~(msg ^ key) with core_done in the 10th cycle after seeing core_start.
    logic       stub_en = 1'b1, man_done = 1'b0, pend = 1'b0;
    logic [3:0] cnt = '0;
    logic [127:0] res = '0;
    always @(posedge clk) begin
        if (core_start && stub_en) begin
            pend <= 1'b1;
            cnt  <= 4'd9;
            res  <= ~(core_msg ^ core_key);
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1'b1;
        end
    end
    assign core_done   = (pend && cnt == 0) || man_done;
    assign core_result = res;

    int nvec = 0, nerr = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(); @(posedge clk); #1; endtask

    task automatic idle_bus();
        bus.initiate = 1'b0; bus.RW = 1'b0; bus.adress = 1'b0;
        bus.start = 1'b0; bus.data_in = '0;
    endtask

    task automatic wr(input logic adr, input logic [31:0] d);
        bus.initiate = 1'b1; bus.RW = 1'b1; bus.adress = adr; bus.data_in = d;
        step();
        bus.initiate = 1'b0;
    endtask

    task automatic do_start(input logic sel);
        bus.start = 1'b1; bus.selCypher = sel;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin step(); n++; end
    endtask

    typedef struct {
        logic        ini;
        logic        rw;
        logic        adr;
        logic [31:0] din;
        logic        exp_oe;
        logic [31:0] exp_dout;
    } vec_t;
    vec_t vt[12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n, starts;
        logic seen;
        logic [31:0] m_msg[MW], m_key[KW], m_res[MW];
        int m_mp, m_kp, m_rp, m_st;   // m_st: 0 idle, 1 running, 2 result held
        logic m_mf, m_kf, m_err, m_mode, m_cs, e_oe;
        logic ini, rw;

        for (int i = 0; i < 4; i++) begin
            vt[i].ini = 1; vt[i].rw = 1; vt[i].adr = 0;
            vt[i].din = (i % 2) ? 32'h89abcdef : 32'h01234567;
            vt[i].exp_oe = 0; vt[i].exp_dout = '0;
            vt[4+i].ini = 1; vt[4+i].rw = 1; vt[4+i].adr = 1;
            vt[4+i].din = 32'habcdefab; vt[4+i].exp_oe = 0; vt[4+i].exp_dout = '0;
            vt[8+i].ini = 1; vt[8+i].rw = 0; vt[8+i].adr = 0; vt[8+i].din = '0;
            vt[8+i].exp_oe = 1;
            vt[8+i].exp_dout = (i % 2) ? 32'hdd99ddbb : 32'h55115533;
        end

        bus.selCypher = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_busy", busy, 0);          chk("rst_rv", result_valid, 0);
        chk("rst_err", err, 0);            chk("rst_cstart", core_start, 0);
        chk("rst_oe", bus.data_oe, 0);     chk("rst_dout", bus.data_out, 0);
        chk("rst_msg", core_msg, 0);       chk("rst_key", core_key, 0);
        chk("rst_mode", core_mode, 0);
        step();

        // Encrypt round trip
        for (int i = 0; i < 8; i++) begin
            bus.initiate = vt[i].ini; bus.RW = vt[i].rw; bus.adress = vt[i].adr; bus.data_in = vt[i].din;
            @(negedge clk);
            chk("wr_oe", bus.data_oe, vt[i].exp_oe);
            step();
            bus.initiate = 1'b0;
        end
        chk("t1_msg", core_msg, {32'h01234567, 32'h89abcdef, 32'h01234567, 32'h89abcdef});
        chk("t1_key", core_key, {4{32'habcdefab}});
        do_start(1'b1);
        chk("t1_mode", core_mode, 1);
        n = 0; starts = 0;
        while (busy && n < 200) begin
            if (core_start) starts++;
            step(); n++;
        end
        chk("t1_busy_cycles", n, 11);
        chk("t1_start_pulses", starts, 1);
        chk("t1_rv", result_valid, 1);
        for (int i = 8; i < 12; i++) begin
            bus.initiate = vt[i].ini; bus.RW = vt[i].rw; bus.adress = vt[i].adr; bus.data_in = vt[i].din;
            @(negedge clk);
            chk("rd_oe", bus.data_oe, vt[i].exp_oe);
            chk("rd_data", bus.data_out, vt[i].exp_dout);
            step();
            bus.initiate = 1'b0;
        end
        chk("t1_err", err, 0);

        // Key persistence: new message only, decrypt
        for (int i = 0; i < 4; i++) wr(1'b0, 32'h76543210);
        do_start(1'b0);
        chk("t2_busy", busy, 1);
        chk("t2_mode", core_mode, 0);
        chk("t2_key", core_key, {4{32'habcdefab}});
        wait_idle(n);
        chk("t2_rv", result_valid, 1);
        bus.initiate = 1'b1; bus.RW = 1'b0;
        @(negedge clk);
        chk("t2_rd", bus.data_out, 32'h22662244);
        step(); bus.initiate = 1'b0;

        // Incomplete load
        do_reset();
        for (int i = 0; i < 4; i++) wr(1'b1, 32'h0f0f0f0f);
        wr(1'b0, 32'h1); wr(1'b0, 32'h2);
        do_start(1'b1);
        seen = core_start;
        for (int i = 0; i < 4; i++) begin step(); seen |= core_start; end
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cstart", seen, 0);

        // Bus misuse
        do_reset();
        bus.initiate = 1'b1; bus.RW = 1'b0;
        @(negedge clk);
        chk("t4_idle_oe", bus.data_oe, 0);
        chk("t4_idle_dout", bus.data_out, 0);
        step(); bus.initiate = 1'b0;
        chk("t4_rd_err", err, 1);
        for (int i = 0; i < 4; i++) wr(1'b0, 32'h0a0a0a00 + i);
        for (int i = 0; i < 4; i++) wr(1'b1, 32'h5a5a5a5a);
        do_start(1'b1);
        chk("t4_err_clr", err, 0);
        wr(1'b0, 32'hdeadbeef);
        chk("t4_msg_kept", core_msg, {32'h0a0a0a00, 32'h0a0a0a01, 32'h0a0a0a02, 32'h0a0a0a03});
        chk("t4_wr_err", err, 1);
        wait_idle(n);

        // Wrap, then reset during RUN
        do_reset();
        for (int i = 0; i < 5; i++) wr(1'b0, 32'h10000000 + i);
        chk("t5_wrap", core_msg, {32'h10000004, 32'h10000001, 32'h10000002, 32'h10000003});
        for (int i = 0; i < 4; i++) wr(1'b1, 32'h33333333);
        do_start(1'b1);
        step();
        chk("t5_busy", busy, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_rst_busy", busy, 0);    chk("t5_rst_err", err, 0);
        chk("t5_rst_msg", core_msg, 0); chk("t5_rst_key", core_key, 0);
        chk("t5_rst_cs", core_start, 0);chk("t5_rst_oe", bus.data_oe, 0);
        step(); step();
        man_done = 1'b1; step(); man_done = 1'b0; step();
        chk("t5_late_rv", result_valid, 0);
        chk("t5_late_busy", busy, 0);
        for (int i = 0; i < 15; i++) step();

`ifdef AES_IF_TIMEOUT_EN
        do_reset();
        stub_en = 1'b0;
        for (int i = 0; i < 4; i++) wr(1'b0, 32'h77);
        for (int i = 0; i < 4; i++) wr(1'b1, 32'h88);
        do_start(1'b1);
        for (int i = 0; i < 19; i++) step();
        chk("tmo_busy_before", busy, 1);
        step();
        chk("tmo_busy", busy, 0);
        chk("tmo_err", err, 1);
        chk("tmo_rv", result_valid, 0);
        stub_en = 1'b1;
`endif

        // Randomized traffic against a word-level model
        do_reset();
        for (int i = 0; i < MW; i++) begin m_msg[i] = '0; m_res[i] = '0; end
        for (int i = 0; i < KW; i++) m_key[i] = '0;
        m_mp = 0; m_kp = 0; m_rp = 0; m_st = 0;
        m_mf = 0; m_kf = 0; m_err = 0; m_mode = 0; m_cs = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.initiate  = 1'($urandom_range(0, 1));
            bus.RW        = ($urandom_range(0, 3) != 0);
            bus.adress    = 1'($urandom_range(0, 1));
            bus.data_in   = $urandom;
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.selCypher = 1'($urandom_range(0, 1));
            @(negedge clk);
            ini = bus.initiate; rw = bus.RW;
            e_oe = ini && !rw && (m_st == 2);
            chk("rnd_oe", bus.data_oe, e_oe);
            chk("rnd_dout", bus.data_out, e_oe ? m_res[m_rp] : 32'h0);
            chk("rnd_busy", busy, m_st == 1);
            chk("rnd_rv", result_valid, m_st == 2);
            chk("rnd_err", err, m_err);
            chk("rnd_cstart", core_start, m_cs);
            chk("rnd_mode", core_mode, m_mode);
            chk("rnd_msg", core_msg, {m_msg[0], m_msg[1], m_msg[2], m_msg[3]});
            chk("rnd_key", core_key, {m_key[0], m_key[1], m_key[2], m_key[3]});

            m_cs = 0;
            if (ini && rw) begin
                if (m_st == 1) m_err = 1;
                else if (bus.adress) begin
                    m_key[m_kp] = bus.data_in;
                    if (m_kp == KW - 1) m_kf = 1;
                    m_kp = (m_kp + 1) % KW;
                end else begin
                    m_msg[m_mp] = bus.data_in;
                    if (m_mp == MW - 1) m_mf = 1;
                    m_mp = (m_mp + 1) % MW;
                end
            end
            if (ini && !rw) begin
                if (m_st == 2) m_rp = (m_rp + 1) % MW;
                else           m_err = 1;
            end
            if (m_st == 1) begin
                if (core_done) begin
                    for (int i = 0; i < MW; i++) m_res[i] = core_result[127-32*i -: 32];
                    m_st = 2;
                end
            end else if (bus.start && !ini) begin
                if (m_mf && m_kf) begin
                    m_st = 1; m_cs = 1; m_mode = bus.selCypher;
                    m_mf = 0; m_rp = 0; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
            step();
        end
        idle_bus();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
